// File: rtl/sram_bus_arbiter_if.sv
// sram-like port bundle: request fields, addr/data handshake, read data.
// master drives the request, slave answers with addr_ok/data_ok/rdata.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like memory port between fetch (inst) and load/store (data).
// Ports: clk, rstn (sync, active-low), inst/data slave ports, mem master port,
// busy (transactions outstanding). Option ARB_ROUND_ROBIN_EN: round-robin ties.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic               clk,
  input  logic               rstn,
  sram_bus_arbiter_if.slave  inst,
  sram_bus_arbiter_if.slave  data,
  sram_bus_arbiter_if.master mem,
  output logic               busy
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    LK_NONE,
    LK_INST,
    LK_DATA
  } lock_e;

  lock_e lock_q, lock_d;

  logic                       sel_vld;
  logic                       sel_data;
  logic                       sel_req;
  logic                       tie_data;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       head;
  logic [MAX_OUTSTANDING-1:0] tags;
  logic [PTR_W-1:0]           wptr, rptr;
  logic [CNT_W-1:0]           count;

`ifdef ARB_ROUND_ROBIN_EN
  // owner of the last accepted push; reset to inst so data wins first tie
  logic rr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q <= 1'b0;
    end else if (push) begin
      rr_q <= sel_data;
    end
  end

  assign tie_data = !rr_q;
`else
  assign tie_data = 1'b1;
`endif

  // a stalled request keeps its owner until the downstream accepts it
  always_comb begin
    sel_vld  = 1'b0;
    sel_data = 1'b0;
    unique case (1'b1)
      lock_q == LK_INST: begin
        sel_vld = 1'b1;
      end
      lock_q == LK_DATA: begin
        sel_vld  = 1'b1;
        sel_data = 1'b1;
      end
      lock_q == LK_NONE && data.req && inst.req: begin
        sel_vld  = 1'b1;
        sel_data = tie_data;
      end
      lock_q == LK_NONE && data.req && !inst.req: begin
        sel_vld  = 1'b1;
        sel_data = 1'b1;
      end
      lock_q == LK_NONE && !data.req && inst.req: begin
        sel_vld = 1'b1;
      end
      default: ;
    endcase
  end

  assign full    = count == CNT_W'(MAX_OUTSTANDING);
  assign sel_req = sel_vld && (sel_data ? data.req : inst.req);
  assign mem.req = sel_req && !full;

  always_comb begin
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.wstrb = 4'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (sel_vld && sel_data) begin
      mem.wr    = data.wr;
      mem.size  = data.size;
      mem.wstrb = data.wstrb;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else if (sel_vld) begin
      mem.wr    = inst.wr;
      mem.size  = inst.size;
      mem.wstrb = inst.wstrb;
      mem.addr  = inst.addr;
      mem.wdata = inst.wdata;
    end
  end

  assign inst.addr_ok = mem.addr_ok && mem.req && !sel_data;
  assign data.addr_ok = mem.addr_ok && mem.req && sel_data;

  // mem.req is already low while full, so full never touches the lock
  always_comb begin
    lock_d = lock_q;
    if (mem.req && mem.addr_ok) begin
      lock_d = LK_NONE;
    end else if (mem.req) begin
      lock_d = sel_data ? LK_DATA : LK_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_q <= LK_NONE;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign push = mem.req && mem.addr_ok;
  assign pop  = mem.data_ok && (count != '0);
  assign head = tags[rptr];

  // depth is a power of two, so pointer overflow is the wrap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tags  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tags[wptr] <= sel_data;
        wptr       <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign inst.data_ok = pop && !head;
  assign data.data_ok = pop && head;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;
  assign busy         = count != '0;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_sram_bus_arbiter;

  localparam int MAXO = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  sram_bus_arbiter_if ii();
  sram_bus_arbiter_if di();
  sram_bus_arbiter_if mi();

  sram_bus_arbiter #(
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .inst(ii),
    .data(di),
    .mem (mi),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ii.req = 0; ii.wr = 0; ii.size = 0; ii.wstrb = 0;
    ii.addr = 0; ii.wdata = 0;
    di.req = 0; di.wr = 0; di.size = 0; di.wstrb = 0;
    di.addr = 0; di.wdata = 0;
    mi.addr_ok = 0; mi.data_ok = 0; mi.rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    tick();
    rstn = 1;
  endtask

  // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy}
  function automatic logic [5:0] ctl();
    return {mi.req, ii.addr_ok, di.addr_ok, ii.data_ok, di.data_ok, busy};
  endfunction

  task automatic test_reset();
    idle();
    rstn = 0;
    tick();
    rstn = 1;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000000) begin
      n_bad++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl(), 6'b0);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    ii.req = 1; ii.addr = 32'h1c000000; ii.size = 2;
    mi.addr_ok = 1;
    settle();
    n_cmp++;
    if (ctl() !== 6'b110000) begin
      n_bad++;
      $display("FAIL fetch_accept got=%b exp=110000", ctl());
    end
    n_cmp++;
    if (mi.addr !== 32'h1c000000) begin
      n_bad++;
      $display("FAIL fetch_addr got=%h exp=1c000000", mi.addr);
    end
    tick();
    ii.req = 0; ii.addr = 0; mi.addr_ok = 0;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000001) begin
      n_bad++;
      $display("FAIL fetch_wait got=%b exp=000001", ctl());
    end
    tick();
    mi.data_ok = 1; mi.rdata = 32'h02800000;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000101) begin
      n_bad++;
      $display("FAIL fetch_ret got=%b exp=000101", ctl());
    end
    n_cmp++;
    if (ii.rdata !== 32'h02800000) begin
      n_bad++;
      $display("FAIL fetch_rdata got=%h exp=02800000", ii.rdata);
    end
    tick();
    mi.data_ok = 0;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000000) begin
      n_bad++;
      $display("FAIL fetch_idle got=%b exp=000000", ctl());
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ii.req = 1; ii.addr = 32'h1c000004;
    di.req = 1; di.addr = 32'h1c0100f0;
    mi.addr_ok = 1;
    settle();
    n_cmp++;
    if (ctl() !== 6'b101000 || mi.addr !== 32'h1c0100f0) begin
      n_bad++;
      $display("FAIL sim_grant0 got=%b/%h exp=101000/1c0100f0",
               ctl(), mi.addr);
    end
    tick();
    di.req = 0; di.addr = 0;
    settle();
    n_cmp++;
    if (ctl() !== 6'b110001 || mi.addr !== 32'h1c000004) begin
      n_bad++;
      $display("FAIL sim_grant1 got=%b/%h exp=110001/1c000004",
               ctl(), mi.addr);
    end
    tick();
    ii.req = 0; mi.addr_ok = 0;
    mi.data_ok = 1; mi.rdata = 32'h0000aaaa;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000011 || di.rdata !== 32'h0000aaaa) begin
      n_bad++;
      $display("FAIL sim_ret0 got=%b/%h exp=000011/0000aaaa",
               ctl(), di.rdata);
    end
    tick();
    mi.rdata = 32'h0000bbbb;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000101 || ii.rdata !== 32'h0000bbbb) begin
      n_bad++;
      $display("FAIL sim_ret1 got=%b/%h exp=000101/0000bbbb",
               ctl(), ii.rdata);
    end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    bit own[4];
    bit exp_d;
    do_reset();
    ii.req = 1; ii.addr = 32'h1c000100;
    di.req = 1; di.addr = 32'h1c010100;
    mi.addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = 1'b1;
`endif
      own[k] = exp_d;
      settle();
      n_cmp++;
      if ({ii.addr_ok, di.addr_ok} !== {!exp_d, exp_d}) begin
        n_bad++;
        $display("FAIL b2b_grant%0d got=%b%b exp=%b%b", k,
                 ii.addr_ok, di.addr_ok, !exp_d, exp_d);
      end
      tick();
    end
    settle();
    n_cmp++;
    if (mi.req !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_full got=%b%b exp=01", mi.req, busy);
    end
    idle();
    mi.data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_cmp++;
      if ({ii.data_ok, di.data_ok} !== {!own[k], own[k]}) begin
        n_bad++;
        $display("FAIL b2b_ret%0d got=%b%b exp=%b%b", k,
                 ii.data_ok, di.data_ok, !own[k], own[k]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    ii.req = 1; ii.addr = 32'h1c000008;
    mi.addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        di.req = 1; di.addr = 32'h1c010000;
      end
      settle();
      n_cmp++;
      if ({mi.req, ii.addr_ok, di.addr_ok} !== 3'b100 ||
          mi.addr !== 32'h1c000008) begin
        n_bad++;
        $display("FAIL lock_hold%0d got=%b%b%b/%h exp=100/1c000008", c,
                 mi.req, ii.addr_ok, di.addr_ok, mi.addr);
      end
      tick();
    end
    mi.addr_ok = 1;
    settle();
    n_cmp++;
    if ({mi.req, ii.addr_ok, di.addr_ok} !== 3'b110 ||
        mi.addr !== 32'h1c000008) begin
      n_bad++;
      $display("FAIL lock_accept got=%b%b%b/%h exp=110/1c000008",
               mi.req, ii.addr_ok, di.addr_ok, mi.addr);
    end
    tick();
    ii.req = 0;
    settle();
    n_cmp++;
    if ({mi.req, ii.addr_ok, di.addr_ok} !== 3'b101 ||
        mi.addr !== 32'h1c010000) begin
      n_bad++;
      $display("FAIL lock_next got=%b%b%b/%h exp=101/1c010000",
               mi.req, ii.addr_ok, di.addr_ok, mi.addr);
    end
    tick();
    idle();
  endtask

  task automatic test_full();
    do_reset();
    di.req = 1; di.wr = 1; di.wstrb = 4'hf; di.size = 2;
    mi.addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      di.addr = 32'h1c020000 + 32'(4 * k);
      di.wdata = 32'(k);
      settle();
      n_cmp++;
      if (di.addr_ok !== 1'b1) begin
        n_bad++;
        $display("FAIL full_fill%0d got=%b exp=1", k, di.addr_ok);
      end
      tick();
    end
    di.addr = 32'h1c020010;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000001) begin
      n_bad++;
      $display("FAIL full_block got=%b exp=000001", ctl());
    end
    tick();
    mi.data_ok = 1;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000011) begin
      n_bad++;
      $display("FAIL full_pop got=%b exp=000011", ctl());
    end
    tick();
    mi.data_ok = 0;
    settle();
    n_cmp++;
    if (ctl() !== 6'b101001) begin
      n_bad++;
      $display("FAIL full_resume got=%b exp=101001", ctl());
    end
    tick();
    idle();
  endtask

  task automatic test_wrap();
    bit ow;
    bit po;
    do_reset();
    for (int t = 0; t < 13; t++) begin
      ii.req = 0; di.req = 0; mi.addr_ok = 0; mi.data_ok = 0;
      ow = t[0];
      if (t < 10) begin
        mi.addr_ok = 1;
        if (ow) begin
          di.req = 1; di.addr = 32'h1c030000 + 32'(t);
        end else begin
          ii.req = 1; ii.addr = 32'h1c030000 + 32'(t);
        end
      end
      if (t >= 3) begin
        mi.data_ok = 1;
        mi.rdata = 32'h5000 + 32'(t - 3);
      end
      settle();
      if (t < 10) begin
        n_cmp++;
        if ({mi.req, ii.addr_ok, di.addr_ok} !== {1'b1, !ow, ow}) begin
          n_bad++;
          $display("FAIL wrap_push%0d got=%b%b%b exp=1%b%b", t,
                   mi.req, ii.addr_ok, di.addr_ok, !ow, ow);
        end
      end
      if (t >= 3) begin
        po = (t - 3) % 2 == 1;
        n_cmp++;
        if ({ii.data_ok, di.data_ok} !== {!po, po} ||
            (po ? di.rdata : ii.rdata) !== 32'h5000 + 32'(t - 3)) begin
          n_bad++;
          $display("FAIL wrap_pop%0d got=%b%b exp=%b%b", t,
                   ii.data_ok, di.data_ok, !po, po);
        end
      end
      tick();
    end
    idle();
    settle();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_drained got=%b exp=0", busy);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ii.req = 1; di.req = 1; mi.addr_ok = 1;
    tick();
    tick();
    idle();
    settle();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    rstn = 0;
    tick();
    rstn = 1;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000000) begin
      n_bad++;
      $display("FAIL mid_reset got=%b exp=000000", ctl());
    end
    mi.data_ok = 1; mi.rdata = 32'hdeadbeef;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000000) begin
      n_bad++;
      $display("FAIL spurious_ok got=%b exp=000000", ctl());
    end
    tick();
    mi.data_ok = 0;
    settle();
    n_cmp++;
    if (ctl() !== 6'b000000) begin
      n_bad++;
      $display("FAIL spurious_after got=%b exp=000000", ctl());
    end
  endtask

  task automatic test_random();
    bit          q[$];
    bit          lk_v, lk_o, last;
    bit          ip, dp;
    logic [70:0] ifl, dfl, ef, gf;
    bit          sv, so, sr, emr, epop, eown;
    logic [5:0]  ectl;
    do_reset();
    lk_v = 0; lk_o = 0; last = 0; ip = 0; dp = 0;
    ifl = '0; dfl = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1;
        ifl = 71'({$urandom(), $urandom(), $urandom()});
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1;
        dfl = 71'({$urandom(), $urandom(), $urandom()});
      end
      ii.req = ip;
      {ii.wr, ii.size, ii.wstrb, ii.addr, ii.wdata} = ifl;
      di.req = dp;
      {di.wr, di.size, di.wstrb, di.addr, di.wdata} = dfl;
      mi.addr_ok = $urandom_range(0, 3) != 0;
      mi.data_ok = $urandom_range(0, 2) == 0;
      mi.rdata = $urandom();
      settle();
      sv = 0; so = 0;
      if (lk_v) begin
        sv = 1; so = lk_o;
      end else if (ip && dp) begin
        sv = 1;
`ifdef ARB_ROUND_ROBIN_EN
        so = !last;
`else
        so = 1;
`endif
      end else if (dp) begin
        sv = 1; so = 1;
      end else if (ip) begin
        sv = 1; so = 0;
      end
      sr = sv && (so ? dp : ip);
      emr = sr && q.size() != MAXO;
      ef = sv ? (so ? dfl : ifl) : '0;
      epop = mi.data_ok && q.size() != 0;
      eown = epop ? q[0] : 1'b0;
      ectl = {emr, mi.addr_ok && emr && !so, mi.addr_ok && emr && so,
              epop && !eown, epop && eown, q.size() != 0};
      n_cmp++;
      if (ctl() !== ectl) begin
        n_bad++;
        $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, ctl(), ectl);
      end
      gf = {mi.wr, mi.size, mi.wstrb, mi.addr, mi.wdata};
      n_cmp++;
      if (gf !== ef) begin
        n_bad++;
        $display("FAIL rnd_fields cyc=%0d got=%h exp=%h", cyc, gf, ef);
      end
      if (epop) begin
        n_cmp++;
        if ((eown ? di.rdata : ii.rdata) !== mi.rdata) begin
          n_bad++;
          $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc,
                   eown ? di.rdata : ii.rdata, mi.rdata);
        end
      end
      tick();
      if (epop) void'(q.pop_front());
      if (emr && mi.addr_ok) begin
        q.push_back(so);
        last = so;
        lk_v = 0;
        if (so) dp = 0;
        else ip = 0;
      end else if (emr) begin
        lk_v = 1;
        lk_o = so;
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_back_to_back();
    test_lock();
    test_full();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
